alu_issue: RTL
==============

# alu_issue

Decode-and-issue stage feeding the RV32I execute-stage ALU. It accepts a fetched instruction word plus register operands over a valid/ready handshake. It decodes the integer ALU instruction classes into the 5-bit ALU operation code and the selected A/B operands, and hands them to the execute stage through a 2-entry skid buffer. Illegal or unsupported encodings are flagged, not dropped.

## Interface
- No parameters. The data width is fixed at 32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1_data / in_rs2_data  in  32 each  register read data.
- out_valid  out  1  issue slot valid.
- out_ready  in  1  execute stage accepts.
- out_alu_op  out  5  bit4 = subtract or arithmetic shift; bit3 = shift right; bits[2:0]: 000 add/sub, 001 shift, 010 pass-B, 100 xor, 110 or, 111 and.
- out_a / out_b  out  32 each  ALU operands.
- out_rd  out  5  destination register.
- out_we  out  1  write-enable: legal and rd≠0.
- out_illegal  out  1  unsupported encoding.
- out_cmp  out  2  compare request: 00 none, 01 SLT, 10 SLTU. Meaningful only with the configuration macro defined.

## Operation
- R-type (opcode 0110011): a=rs1, b=rs2. funct3 maps 000→000, 001→001 (left), 101→001 with bit3=1, 100→100, 110→110, 111→111. funct7[5]=1 sets bit4 only for funct3 000/101. Any other funct7 value is illegal.
- I-type ALU (0010011): a=rs1, b=sign-extended inst[31:20]. ADDI never sets bit4. SLLI/SRLI require inst[31:25]=0. SRAI requires inst[31:25]=0100000 and sets bit4. Other shift-immediate values are illegal.
- LUI (0110111): op=00010, a=0, b={inst[31:12],12'b0}.
- AUIPC (0010111): op=00000, a=pc, b={inst[31:12],12'b0}.
- funct3 010/011 (SLT/SLTU): see Configuration.
- Illegal or other opcodes: out_illegal=1, op=00010, a=0, b=0, out_we=0, out_cmp=00. The word is still issued.
- Skid buffer FSM, state register cnt:
  - EMPTY: accept → ONE.
  - ONE: accept only → FULL (decoded entry in skid slot); deliver only → EMPTY; accept and deliver → ONE, with new data in the output slot.
  - FULL: deliver → ONE, skid slot moves to output. No accept is possible.
- accept = in_valid & in_ready; deliver = out_valid & out_ready.
- in_ready = (cnt≠FULL), decoded from registered state only. There is no combinational path out_ready→in_ready.
- out_valid = (cnt≠EMPTY). Output fields stay stable while out_valid & !out_ready.
- flush: next state EMPTY and both slots invalidated. It overrides a simultaneous accept and deliver; the input word is discarded.

## Timing
- Latency: word accepted at edge N appears on the outputs after edge N (valid in cycle N+1).
- Throughput: 1 word/cycle while out_ready is held high.
- Reset (asynchronous, rst_n=0): cnt=EMPTY, out_valid=0, in_ready=1, all data outputs 0, out_illegal=0, out_cmp=00.
- Reset asserted mid-transfer loses both slots. There is no partial delivery.
- Up to 2 words are held. The third offered word stalls with in_ready=0 until a deliver occurs.

## Configuration
- ALU_ISSUE_SLT_EN defined: funct3 010/011 (R and I forms) decode to op=10000 (subtract), with out_cmp=01/10 respectively. Execute resolves the sign/carry.
- Undefined: these encodings are illegal. out_cmp is tied to 00 and its logic is absent.

## Test plan
- Reset, then offer ADD x3,x1,x2 with rs1=5, rs2=7 and out_ready=1 → next cycle out_valid=1, op=00000, a=5, b=7, rd=3, we=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 → op=11001, b=0x404; SLLI with inst[31:25]=0000001 → illegal=1, we=0.
- LUI x1,0xABCDE → op=00010, b=0xABCDE000. AUIPC at pc=0x100 → a=0x100, op=00000.
- Hold out_ready=0 and offer 3 words → in_ready drops after the 2nd accept, outputs stay frozen. Raise out_ready → words emerge in order on 2 consecutive cycles.
- In FULL, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed word never appears.
- SLT x4,x1,x2 → with the macro defined: op=10000, cmp=01. Without it: illegal=1, cmp=00.

Source files
------------

// File: rtl/alu_issue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_issue
// Decode-and-issue stage in front of the RV32I execute-stage ALU.
// It decodes the integer ALU instruction classes (R-type, I-type ALU, LUI and
// AUIPC) into a 5-bit ALU op code and the A/B operands. The decoded result is
// handed to execute through a 2-entry skid buffer with a valid/ready handshake.
// Unsupported encodings are still issued, with out_illegal set.
//
// Optional feature macro: ALU_ISSUE_SLT_EN
//   defined   : SLT/SLTU/SLTI/SLTIU decode to subtract with an out_cmp request
//   undefined : those encodings are illegal and out_cmp is tied to 2'b00
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush that empties both buffer slots
//   in_valid/in_ready   upstream handshake
//   in_inst, in_pc      instruction word and its address
//   in_rs1_data/rs2     register read data
//   out_valid/out_ready downstream handshake
//   out_alu_op          {sub/arith, shift-right, class[2:0]}
//   out_a, out_b        ALU operands
//   out_rd, out_we      destination register, write enable (legal and rd != 0)
//   out_illegal         unsupported encoding flag
//   out_cmp             compare request: 00 none, 01 SLT, 10 SLTU
// -----------------------------------------------------------------------------
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_alu_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal,
    output logic [1:0]  out_cmp
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [4:0] OP_ADD     = 5'b00000;
    localparam logic [4:0] OP_SUB     = 5'b10000;
    localparam logic [4:0] OP_SLL     = 5'b00001;
    localparam logic [4:0] OP_SRL     = 5'b01001;
    localparam logic [4:0] OP_SRA     = 5'b11001;
    localparam logic [4:0] OP_PASS_B  = 5'b00010;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
`ifdef ALU_ISSUE_SLT_EN
        logic [1:0]  cmp;
`endif
    } issue_t;

    cnt_t   cnt_reg, cnt_next;
    issue_t out_slot_reg, out_slot_next;
    issue_t skid_slot_reg, skid_slot_next;
    issue_t dec;

    logic       accept;
    logic       deliver;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[11:7];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_u  = {in_inst[31:12], 12'b0};

    // ---------------------------------------------------------------------
    // Instruction decode
    // ---------------------------------------------------------------------
    always_comb begin
        logic legal;
        legal   = 1'b0;
        dec     = '0;
        dec.op  = OP_PASS_B;
        dec.rd  = rd;
        case (opcode)
            OPC_OP: begin
                dec.a = in_rs1_data;
                dec.b = in_rs2_data;
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ZERO) begin
                            legal  = 1'b1;
                            dec.op = OP_ADD;
                        end else if (f7 == F7_ALT) begin
                            legal  = 1'b1;
                            dec.op = OP_SUB;
                        end
                    end
                    3'b001: begin
                        if (f7 == F7_ZERO) begin
                            legal  = 1'b1;
                            dec.op = OP_SLL;
                        end
                    end
                    3'b101: begin
                        if (f7 == F7_ZERO) begin
                            legal  = 1'b1;
                            dec.op = OP_SRL;
                        end else if (f7 == F7_ALT) begin
                            legal  = 1'b1;
                            dec.op = OP_SRA;
                        end
                    end
                    3'b100, 3'b110, 3'b111: begin
                        if (f7 == F7_ZERO) begin
                            legal  = 1'b1;
                            dec.op = {2'b00, f3};
                        end
                    end
`ifdef ALU_ISSUE_SLT_EN
                    3'b010, 3'b011: begin
                        if (f7 == F7_ZERO) begin
                            legal   = 1'b1;
                            dec.op  = OP_SUB;
                            dec.cmp = f3[0] ? 2'b10 : 2'b01;
                        end
                    end
`endif
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.a = in_rs1_data;
                dec.b = imm_i;
                case (f3)
                    // ADDI has no subtract form, so inst[30] is ignored here
                    3'b000: begin
                        legal  = 1'b1;
                        dec.op = OP_ADD;
                    end
                    3'b001: begin
                        if (f7 == F7_ZERO) begin
                            legal  = 1'b1;
                            dec.op = OP_SLL;
                        end
                    end
                    3'b101: begin
                        if (f7 == F7_ZERO) begin
                            legal  = 1'b1;
                            dec.op = OP_SRL;
                        end else if (f7 == F7_ALT) begin
                            legal  = 1'b1;
                            dec.op = OP_SRA;
                        end
                    end
                    3'b100, 3'b110, 3'b111: begin
                        legal  = 1'b1;
                        dec.op = {2'b00, f3};
                    end
`ifdef ALU_ISSUE_SLT_EN
                    3'b010, 3'b011: begin
                        legal   = 1'b1;
                        dec.op  = OP_SUB;
                        dec.cmp = f3[0] ? 2'b10 : 2'b01;
                    end
`endif
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal  = 1'b1;
                dec.op = OP_PASS_B;
                dec.a  = '0;
                dec.b  = imm_u;
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                dec.op = OP_ADD;
                dec.a  = in_pc;
                dec.b  = imm_u;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words travel as a harmless pass-B of zero with no writeback
        if (!legal) begin
            dec.op = OP_PASS_B;
            dec.a  = '0;
            dec.b  = '0;
`ifdef ALU_ISSUE_SLT_EN
            dec.cmp = 2'b00;
`endif
        end
        dec.illegal = !legal;
        dec.we      = legal && (rd != 5'd0);
    end

    // ---------------------------------------------------------------------
    // Skid buffer: output slot drives the ports, skid slot catches the word
    // accepted while the output slot is stalled.
    // ---------------------------------------------------------------------
    assign in_ready  = (cnt_reg != FULL);
    assign out_valid = (cnt_reg != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        cnt_next       = cnt_reg;
        out_slot_next  = out_slot_reg;
        skid_slot_next = skid_slot_reg;
        if (flush) begin
            cnt_next       = EMPTY;
            out_slot_next  = '0;
            skid_slot_next = '0;
        end else begin
            case (cnt_reg)
                EMPTY: begin
                    if (accept) begin
                        out_slot_next = dec;
                        cnt_next      = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        out_slot_next = dec;
                    end else if (accept) begin
                        skid_slot_next = dec;
                        cnt_next       = FULL;
                    end else if (deliver) begin
                        cnt_next = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        out_slot_next = skid_slot_reg;
                        cnt_next      = ONE;
                    end
                end
                default: cnt_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= EMPTY;
            out_slot_reg  <= '0;
            skid_slot_reg <= '0;
        end else begin
            cnt_reg       <= cnt_next;
            out_slot_reg  <= out_slot_next;
            skid_slot_reg <= skid_slot_next;
        end
    end

    assign out_alu_op  = out_slot_reg.op;
    assign out_a       = out_slot_reg.a;
    assign out_b       = out_slot_reg.b;
    assign out_rd      = out_slot_reg.rd;
    assign out_we      = out_slot_reg.we;
    assign out_illegal = out_slot_reg.illegal;
`ifdef ALU_ISSUE_SLT_EN
    assign out_cmp     = out_slot_reg.cmp;
`else
    assign out_cmp     = 2'b00;
`endif

endmodule
